// File: rtl/load_store_unit_pkg.sv
// Shared RV32I definitions: LSU state encoding, load/store funct3 codes,
// data-bus request record and request legality helpers.
package riscv_defs;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            we;
  } bus_req_t;

  function automatic logic lsu_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3);
    logic ld_ok;
    logic st_ok;
    ld_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
            (f3 == F3_LBU) || (f3 == F3_LHU);
    st_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (rd & wr) | (rd & ~ld_ok) | (wr & ~st_ok);
  endfunction

  // Size lives in funct3[1:0]; only meaningful once the request is known legal.
  function automatic logic lsu_misaligned(input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) & addr_lo[0]) |
           ((f3[1:0] == 2'b10) & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replication on the way out,
// lane extraction with sign/zero extension on the way back.
module lsu_align
  import riscv_defs::*;
(
  input  logic [2:0]      st_funct3_i,
  input  logic [1:0]      st_addr_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [3:0]      st_be_o,
  output logic [XLEN-1:0] st_wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half   = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data_o = {24'h0, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data_o = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/ack data-bus transaction per request, with
// fault reporting for illegal/misaligned requests and bus timeouts.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int unsigned NB_WORD        = 32,
  parameter int unsigned NB_REG         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_dmem_rd,
  input  logic               i_dmem_wr,
  input  logic [2:0]         i_ld_st_funct3,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [NB_WORD-1:0] i_addr,
  input  logic [NB_WORD-1:0] i_store_data,
  output logic               o_busy,
  output logic               o_bus_req,
  output logic               o_bus_we,
  output logic [NB_WORD-1:0] o_bus_addr,
  output logic [3:0]         o_bus_be,
  output logic [NB_WORD-1:0] o_bus_wdata,
  input  logic               i_bus_ack,
  input  logic [NB_WORD-1:0] i_bus_rdata,
  output logic               o_ld_valid,
  output logic [NB_WORD-1:0] o_ld_data,
  output logic [NB_REG-1:0]  o_ld_rd,
  output logic               o_misaligned,
  output logic               o_illegal,
  output logic               o_bus_error,
  output logic [NB_WORD-1:0] o_fault_addr
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t         state_q;
  bus_req_t           bus_q;
  logic               req_q;
  logic [NB_WORD-1:0] addr_q;
  logic [2:0]         f3_q;
  logic [NB_REG-1:0]  rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ld_valid_q;
  logic [NB_WORD-1:0] ld_data_q;
  logic               mis_q;
  logic               ill_q;
  logic               berr_q;
  logic [NB_WORD-1:0] fault_addr_q;

  logic               accept;
  logic               illegal_d;
  logic               misaligned_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [3:0]         st_be;
  logic [NB_WORD-1:0] st_wdata;
  logic [NB_WORD-1:0] ld_ext;

  assign accept       = i_valid & (i_dmem_rd | i_dmem_wr);
  assign illegal_d    = lsu_illegal(i_dmem_rd, i_dmem_wr, i_ld_st_funct3);
  assign misaligned_d = ~illegal_d & lsu_misaligned(i_ld_st_funct3, i_addr[1:0]);
  assign cnt_d        = cnt_q + 1'b1;

  lsu_align u_align (
    .st_funct3_i  (i_ld_st_funct3),
    .st_addr_lo_i (i_addr[1:0]),
    .st_data_i    (i_store_data),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (i_bus_rdata),
    .ld_data_o    (ld_ext)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      bus_q        <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      ld_valid_q   <= 1'b0;
      ld_data_q    <= '0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
      berr_q       <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      ld_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      berr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q      <= i_addr;
            f3_q        <= i_ld_st_funct3;
            rd_q        <= i_rd;
            bus_q.addr  <= {i_addr[NB_WORD-1:2], 2'b00};
            bus_q.be    <= st_be;
            bus_q.wdata <= st_wdata;
            bus_q.we    <= i_dmem_wr;
            if (illegal_d || misaligned_d) begin
              ill_q        <= illegal_d;
              mis_q        <= misaligned_d;
              fault_addr_q <= i_addr;
            end else begin
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          // Ack is checked before the limit so a last-cycle ack still completes.
          if (i_bus_ack) begin
            req_q <= 1'b0;
            if (bus_q.we) begin
              state_q <= IDLE;
            end else begin
              ld_data_q  <= ld_ext;
              ld_valid_q <= 1'b1;
              state_q    <= RESP;
            end
          end else if (cnt_d == CNT_LIM) begin
            req_q        <= 1'b0;
            berr_q       <= 1'b1;
            fault_addr_q <= addr_q;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_bus_req    = req_q;
  assign o_bus_we     = bus_q.we;
  assign o_bus_addr   = bus_q.addr;
  assign o_bus_be     = bus_q.be;
  assign o_bus_wdata  = bus_q.wdata;
  assign o_ld_valid   = ld_valid_q;
  assign o_ld_data    = ld_data_q;
  assign o_ld_rd      = rd_q;
  assign o_misaligned = mis_q;
  assign o_illegal    = ill_q;
  assign o_bus_error  = berr_q;
  assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver pushes expected bus/load/fault
// events computed by a byte-level reference model; a monitor pops and compares.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_dmem_rd, i_dmem_wr;
  logic [2:0]  i_ld_st_funct3;
  logic [4:0]  i_rd;
  logic [31:0] i_addr, i_store_data;
  logic        o_busy, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        o_ld_valid;
  logic [31:0] o_ld_data;
  logic [4:0]  o_ld_rd;
  logic        o_misaligned, o_illegal, o_bus_error;
  logic [31:0] o_fault_addr;

  load_store_unit #(.NB_WORD(32), .NB_REG(5), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_dmem_rd(i_dmem_rd),
    .i_dmem_wr(i_dmem_wr), .i_ld_st_funct3(i_ld_st_funct3), .i_rd(i_rd),
    .i_addr(i_addr), .i_store_data(i_store_data), .o_busy(o_busy),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data),
    .o_ld_rd(o_ld_rd), .o_misaligned(o_misaligned), .o_illegal(o_illegal),
    .o_bus_error(o_bus_error), .o_fault_addr(o_fault_addr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          ncyc;
    int unsigned cyc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int unsigned cyc;
  } ld_exp_t;

  typedef struct {
    logic [2:0]  kind;  // {bus_error, illegal, misaligned}
    logic [31:0] addr;
    int unsigned cyc;
  } flt_exp_t;

  bus_exp_t bus_q[$];
  ld_exp_t  ld_q[$];
  flt_exp_t flt_q[$];

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
    int nb;
    int lane;
    longint unsigned mask;
    longint unsigned v;
    nb   = 1 << f3[1:0];
    lane = (int'(a[1:0]) / nb) * nb;
    mask = (64'd1 << (8 * nb)) - 1;
    v    = ({32'd0, r} >> (8 * lane)) & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Monitor: compares every DUT-presented event against the queue heads.
  int reqcnt   = 0;
  bit prev_req = 0;
  always @(negedge clk) begin
    if (o_bus_req === 1'b1) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
      else begin
        if (reqcnt == 0) chk("req_start_cyc", 64'(cyc), 64'(bus_q[0].cyc));
        chk("bus_addr", o_bus_addr, bus_q[0].addr);
        chk("bus_be", o_bus_be, bus_q[0].be);
        chk("bus_we", o_bus_we, bus_q[0].we);
        if (bus_q[0].we) chk("bus_wdata", o_bus_wdata, bus_q[0].wdata);
      end
      reqcnt++;
    end else if (prev_req && bus_q.size() > 0) begin
      chk("req_len", 64'(reqcnt), 64'(bus_q[0].ncyc));
      void'(bus_q.pop_front());
      reqcnt = 0;
    end
    prev_req = (o_bus_req === 1'b1);

    if (o_ld_valid === 1'b1) begin
      if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
      else begin
        chk("ld_data", o_ld_data, ld_q[0].data);
        chk("ld_rd", o_ld_rd, ld_q[0].rd);
        chk("ld_cyc", 64'(cyc), 64'(ld_q[0].cyc));
        void'(ld_q.pop_front());
      end
    end

    if ((o_misaligned | o_illegal | o_bus_error) === 1'b1) begin
      if (flt_q.size() == 0) chk("fault_unexpected", 1, 0);
      else begin
        chk("fault_kind", {o_bus_error, o_illegal, o_misaligned}, flt_q[0].kind);
        chk("fault_addr", o_fault_addr, flt_q[0].addr);
        chk("fault_cyc", 64'(cyc), 64'(flt_q[0].cyc));
        void'(flt_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (o_busy !== 1'b0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("busy_wait_expired", 1, 0);
  endtask

  // w = wait cycles before ack; w >= T means the bus never acks.
  task automatic issue(input bit rdv, input bit wrv, input logic [2:0] f3,
                       input logic [4:0] rdi, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input int w);
    int          nb;
    int          lane;
    bit          ill, mis, legal;
    bus_exp_t    be;
    logic [31:0] wd;
    int unsigned n;
    wait_idle();
    n    = cyc;
    nb   = 1 << f3[1:0];
    lane = (int'(a[1:0]) / nb) * nb;
    ill  = (rdv && wrv) || (rdv && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
           (wrv && !(f3 inside {3'd0, 3'd1, 3'd2}));
    mis  = !ill && (int'(a[1:0]) % nb != 0);
    legal = (rdv || wrv) && !ill && !mis;
    if (rdv || wrv) begin
      if (ill) flt_q.push_back('{3'b010, a, n + 1});
      else if (mis) flt_q.push_back('{3'b001, a, n + 1});
      else begin
        for (int j = 0; j < 4; j++) wd[8*j +: 8] = sd[8*(j % nb) +: 8];
        be.addr  = {a[31:2], 2'b00};
        be.be    = 4'(((1 << nb) - 1) << lane);
        be.wdata = wd;
        be.we    = wrv;
        be.ncyc  = (w < T) ? w + 1 : T;
        be.cyc   = n + 1;
        bus_q.push_back(be);
        if (w >= T) flt_q.push_back('{3'b100, a, n + 1 + T});
        else if (rdv) ld_q.push_back('{ld_model(f3, a, rdat), rdi, n + 2 + w});
      end
    end
    i_valid = 1'b1; i_dmem_rd = rdv; i_dmem_wr = wrv; i_ld_st_funct3 = f3;
    i_rd = rdi; i_addr = a; i_store_data = sd;
    @(posedge clk); #1;
    i_valid = 1'b0; i_dmem_rd = $urandom; i_dmem_wr = $urandom;
    i_addr = $urandom; i_store_data = $urandom;
    if (legal && w < T) begin
      repeat (w) begin
        i_bus_rdata = $urandom;
        @(posedge clk); #1;
      end
      i_bus_ack = 1'b1; i_bus_rdata = rdat;
      @(posedge clk); #1;
      i_bus_ack = 1'b0; i_bus_rdata = $urandom;
    end
  endtask

  initial begin
    bus_exp_t rb;
    rst = 1'b1;
    i_valid = 0; i_dmem_rd = 0; i_dmem_wr = 0; i_ld_st_funct3 = 0; i_rd = 0;
    i_addr = 0; i_store_data = 0; i_bus_ack = 0; i_bus_rdata = 0;
    @(negedge clk);
    chk("reset_ctrl", {o_busy, o_bus_req, o_bus_we, o_ld_valid, o_misaligned, o_illegal, o_bus_error}, 0);
    chk("reset_bus", {o_bus_addr, o_bus_wdata}, 0);
    chk("reset_misc", {o_bus_be, o_ld_data, o_ld_rd, o_fault_addr[22:0]}, 0);
    @(posedge clk); #1 rst = 1'b0;

    issue(0, 1, 3'b000, 5'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2);
    issue(1, 0, 3'b000, 5'd7, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0);
    issue(1, 0, 3'b100, 5'd8, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0);
    issue(1, 0, 3'b001, 5'd9, 32'h0000_2002, 32'h0, 32'h8001_0000, 1);
    issue(1, 0, 3'b010, 5'd3, 32'h0000_2002, 32'h0, 32'h0, 0);
    issue(1, 0, 3'b011, 5'd4, 32'h0000_3000, 32'h0, 32'h0, 0);
    issue(1, 1, 3'b000, 5'd5, 32'h0000_3004, 32'h0, 32'h0, 0);
    issue(0, 1, 3'b011, 5'd5, 32'h0000_3008, 32'h0, 32'h0, 0);
    issue(0, 0, 3'b010, 5'd6, 32'h0000_300C, 32'h0, 32'h0, 0);
    issue(1, 0, 3'b010, 5'd10, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, T);
    issue(1, 0, 3'b010, 5'd11, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, T - 1);
    issue(0, 1, 3'b001, 5'd0, 32'h0000_4006, 32'h0000_BEEF, 32'h0, T);

    // Reset in the middle of an open load: req and busy drop at once, no pulses.
    wait_idle();
    rb = '{32'h0000_5000, 4'b1111, 32'h0, 1'b0, 1, cyc + 1};
    bus_q.push_back(rb);
    i_valid = 1; i_dmem_rd = 1; i_dmem_wr = 0; i_ld_st_funct3 = 3'b010;
    i_rd = 5'd12; i_addr = 32'h0000_5000;
    @(posedge clk); #1 i_valid = 0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rst_async_req", o_bus_req, 0);
    chk("rst_async_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(1, 0, 3'b101, 5'd13, 32'h0000_5002, 32'h0, 32'hF00D_1234, 1);

    for (int k = 0; k < 80; k++) begin
      int sel;
      bit rdv, wrv;
      logic [2:0] f3;
      sel = $urandom_range(0, 9);
      rdv = (sel < 5) || (sel == 9);
      wrv = (sel >= 5);
      if (sel == 8) begin rdv = 0; wrv = 0; end
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) :
           (rdv ? 3'(($urandom_range(0, 4) + 0) % 5 + (($urandom_range(0, 4) % 5) >= 3 ? 1 : 0)) :
                  3'($urandom_range(0, 2)));
      issue(rdv, wrv, f3, 5'($urandom), {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom_range(0, T));
    end

    wait_idle();
    repeat (T + 4) @(posedge clk);
    #1;
    chk("bus_q_empty", 64'(bus_q.size()), 0);
    chk("ld_q_empty", 64'(ld_q.size()), 0);
    chk("flt_q_empty", 64'(flt_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
